// File: rtl/data_mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// CoreConfig: definitions shared by the execute stage and the data memory
// responder.
//   mem_state_e : responder FSM states (IDLE, LOAD_WAIT)
//   MEM_BYTE/MEM_HALF/MEM_WORD : access width encoding on ram_*_width
//   lane_mask()     : right-justified data mask for an access width
//   is_misaligned() : alignment rule for a width/byte-offset pair
// -----------------------------------------------------------------------------
package CoreConfig;

  typedef enum logic {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } mem_state_e;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  // Mask applied to right-justified load data; the reserved width yields 0.
  function automatic logic [31:0] lane_mask(input logic [1:0] width);
    case (width)
      MEM_BYTE: return 32'h0000_00FF;
      MEM_HALF: return 32'h0000_FFFF;
      MEM_WORD: return 32'hFFFF_FFFF;
      default:  return 32'h0000_0000;
    endcase
  endfunction

  // Halfwords need an even offset, words offset 0; width 2'b11 is never legal.
  function automatic logic is_misaligned(input logic [1:0] width,
                                         input logic [1:0] offset);
    case (width)
      MEM_BYTE: return 1'b0;
      MEM_HALF: return offset[0];
      MEM_WORD: return (offset != 2'b00);
      default:  return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// -----------------------------------------------------------------------------
// data_mem_if: execute-stage request/response signals plus the SRAM port of
// the data memory responder.
//   modport master : execute stage and SRAM side (drives requests, sram_rdata)
//   modport slave  : the responder (drives load data, stall, fault, SRAM strobes)
// -----------------------------------------------------------------------------
interface data_mem_if #(
  parameter int ADDR_W = 10
);

  logic              ram_load_en;
  logic              ram_store_en;
  logic [31:0]       ram_load_addr;
  logic [31:0]       ram_store_addr;
  logic [31:0]       ram_store_data;
  logic [1:0]        ram_store_width;
  logic [1:0]        ram_load_width;
  logic [31:0]       ram_load_data;
  logic              mem_stall;
  logic              access_fault;
  logic              sram_en;
  logic [3:0]        sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [31:0]       sram_wdata;
  logic [31:0]       sram_rdata;

  modport master (
    output ram_load_en, ram_store_en, ram_load_addr, ram_store_addr,
           ram_store_data, ram_store_width, ram_load_width, sram_rdata,
    input  ram_load_data, mem_stall, access_fault,
           sram_en, sram_we, sram_addr, sram_wdata
  );

  modport slave (
    input  ram_load_en, ram_store_en, ram_load_addr, ram_store_addr,
           ram_store_data, ram_store_width, ram_load_width, sram_rdata,
    output ram_load_data, mem_stall, access_fault,
           sram_en, sram_we, sram_addr, sram_wdata
  );

endinterface

// File: rtl/data_mem_responder_lane_align.sv
// -----------------------------------------------------------------------------
// mem_lane_align: combinational lane steering for the data memory.
//   Write path: wr_off_i/wr_width_i/wr_data_i -> byte enables wr_be_o and
//               lane-replicated write data wr_lanes_o.
//   Read path : rd_off_i/rd_width_i/rd_data_i -> right-justified, width-masked
//               load data rd_data_o.
// -----------------------------------------------------------------------------
module mem_lane_align
  import CoreConfig::*;
(
  input  logic [1:0]  wr_off_i,
  input  logic [1:0]  wr_width_i,
  input  logic [31:0] wr_data_i,
  output logic [3:0]  wr_be_o,
  output logic [31:0] wr_lanes_o,
  input  logic [1:0]  rd_off_i,
  input  logic [1:0]  rd_width_i,
  input  logic [31:0] rd_data_i,
  output logic [31:0] rd_data_o
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    wr_be_o    = 4'b0000;
    wr_lanes_o = 32'h0000_0000;
    case (wr_width_i)
      MEM_BYTE: begin
        wr_be_o    = 4'b0001 << wr_off_i;
        wr_lanes_o = {4{wr_data_i[7:0]}};
      end
      MEM_HALF: begin
        wr_be_o    = 4'b0011 << wr_off_i;
        wr_lanes_o = {2{wr_data_i[15:0]}};
      end
      MEM_WORD: begin
        wr_be_o    = 4'b1111;
        wr_lanes_o = wr_data_i;
      end
      default: ;
    endcase
  end

  assign rd_data_o = (rd_data_i >> {rd_off_i, 3'b000}) & lane_mask(rd_width_i);

endmodule

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder: serves execute-stage loads/stores from a single-port
// synchronous SRAM mapped at a 2^(ADDR_W+2)-byte window starting at BASE_ADDR.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : data_mem_if.slave (request/response and SRAM signals)
// Stores complete in the request cycle. Loads stall one cycle and return data
// in LOAD_WAIT; the returned value is held until the next load completes.
// Misaligned or out-of-window requests pulse access_fault and never reach the
// SRAM. With load and store together the store goes first under stall.
// -----------------------------------------------------------------------------
module data_mem_responder #(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000
) (
  input logic     clk,
  input logic     rst_n,
  data_mem_if.slave bus
);

  import CoreConfig::*;

  mem_state_e  state_q;
  logic [1:0]  off_q;
  logic [1:0]  width_q;
  logic [31:0] hold_q;
  logic        store_done_q;  // store half of a combined request already served

  logic        st_ok, ld_ok;
  logic        idle, store_phase, load_phase, store_go, load_go;
  logic [3:0]  wr_be;
  logic [31:0] wr_lanes;
  logic [31:0] rd_value;

  assign st_ok = (bus.ram_store_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]) &&
                 !is_misaligned(bus.ram_store_width, bus.ram_store_addr[1:0]);
  assign ld_ok = (bus.ram_load_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]) &&
                 !is_misaligned(bus.ram_load_width, bus.ram_load_addr[1:0]);

  // The request decode is qualified by rst_n so the combinational SRAM strobes,
  // stall and fault stay low for the whole reset, even with requests present.
  assign idle = rst_n && (state_q == IDLE);

  // A combined request is split: the store is served first, and on the next
  // cycle (store_done_q set, core still holding both) only the load proceeds.
  assign store_phase = idle && bus.ram_store_en && !(store_done_q && bus.ram_load_en);
  assign load_phase  = idle && bus.ram_load_en && !store_phase;
  assign store_go    = store_phase && st_ok;
  assign load_go     = load_phase && ld_ok;

  mem_lane_align u_lane_align (
    .wr_off_i   (bus.ram_store_addr[1:0]),
    .wr_width_i (bus.ram_store_width),
    .wr_data_i  (bus.ram_store_data),
    .wr_be_o    (wr_be),
    .wr_lanes_o (wr_lanes),
    .rd_off_i   (off_q),
    .rd_width_i (width_q),
    .rd_data_i  (bus.sram_rdata),
    .rd_data_o  (rd_value)
  );

  always_comb begin
    bus.sram_en    = 1'b0;
    bus.sram_we    = 4'b0000;
    bus.sram_addr  = '0;
    bus.sram_wdata = 32'h0000_0000;
    if (store_go) begin
      bus.sram_en    = 1'b1;
      bus.sram_we    = wr_be;
      bus.sram_addr  = bus.ram_store_addr[ADDR_W+1:2];
      bus.sram_wdata = wr_lanes;
    end else if (load_go) begin
      bus.sram_en    = 1'b1;
      bus.sram_addr  = bus.ram_load_addr[ADDR_W+1:2];
    end
  end

  assign bus.mem_stall     = (store_phase && bus.ram_load_en) || load_go;
  assign bus.access_fault  = (store_phase && !st_ok) || (load_phase && !ld_ok);
  assign bus.ram_load_data = (state_q == LOAD_WAIT) ? rd_value : hold_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      off_q        <= 2'b00;
      width_q      <= MEM_BYTE;
      hold_q       <= 32'h0000_0000;
      store_done_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      store_done_q <= store_phase && bus.ram_load_en;
      case (state_q)
        IDLE: begin
          if (load_go) begin
            off_q   <= bus.ram_load_addr[1:0];
            width_q <= bus.ram_load_width;
            state_q <= LOAD_WAIT;
          end else if (load_phase) begin
            hold_q  <= 32'h0000_0000;  // faulting load returns zero
          end
        end
        LOAD_WAIT: begin
          hold_q  <= rd_value;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// Self-checking bench for data_mem_responder. A behavioural SRAM answers the
// DUT's strobes; a separate shadow memory, updated only from the stimulus the
// bench issues, supplies every expected value through two scoreboard queues
// (SRAM-port expectations for stores, load data for loads).
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [1:0]  W_B  = 2'b00;
  localparam logic [1:0]  W_H  = 2'b01;
  localparam logic [1:0]  W_W  = 2'b10;

  typedef struct packed {
    logic        en;
    logic [3:0]  we;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic        fault;
    logic        stall;
  } sram_exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  sram_exp_t   sq[$];
  logic [31:0] lq[$];

  logic [31:0] sram   [0:1023] = '{default: 32'h0};
  logic [31:0] shadow [0:1023] = '{default: 32'h0};

  data_mem_if #(.ADDR_W(10)) bus ();

  data_mem_responder #(.ADDR_W(10), .BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural synchronous SRAM: byte-enabled write, one-cycle read.
  always @(posedge clk) begin
    if (bus.sram_en) begin
      if (bus.sram_we != 4'b0000) begin
        for (int b = 0; b < 4; b++)
          if (bus.sram_we[b]) sram[bus.sram_addr][8*b +: 8] <= bus.sram_wdata[8*b +: 8];
      end else begin
        bus.sram_rdata <= sram[bus.sram_addr];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------- model
  function automatic int nbytes(input logic [1:0] w);
    case (w)
      W_B:     return 1;
      W_H:     return 2;
      W_W:     return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic legal(input logic [31:0] a, input logic [1:0] w);
    int n;
    n = nbytes(w);
    if (n == 0) return 1'b0;
    if ((a & 32'hFFFF_F000) != BASE) return 1'b0;
    return (int'(a[1:0]) % n) == 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] w);
    logic [31:0] word, r;
    r    = 32'h0;
    word = shadow[a[11:2]];
    for (int i = 0; i < nbytes(w); i++) r[8*i +: 8] = word[8*(int'(a[1:0]) + i) +: 8];
    return r;
  endfunction

  function automatic sram_exp_t model_store(input logic [31:0] a, input logic [1:0] w,
                                            input logic [31:0] d, input logic stall);
    sram_exp_t e;
    int n, off;
    e       = '0;
    e.stall = stall;
    e.fault = !legal(a, w);
    if (!e.fault) begin
      n      = nbytes(w);
      off    = int'(a[1:0]);
      e.en   = 1'b1;
      e.addr = a[11:2];
      for (int b = 0; b < 4; b++) begin
        e.we[b]            = (b >= off) && (b < off + n);
        e.wdata[8*b +: 8]  = d[8*(b % n) +: 8];
      end
    end
    return e;
  endfunction

  function automatic void shadow_write(input sram_exp_t e);
    for (int b = 0; b < 4; b++)
      if (e.en && e.we[b]) shadow[e.addr][8*b +: 8] = e.wdata[8*b +: 8];
  endfunction

  function automatic sram_exp_t observe();
    sram_exp_t o;
    o = {bus.sram_en, bus.sram_we, bus.sram_addr, bus.sram_wdata,
         bus.access_fault, bus.mem_stall};
    return o;
  endfunction

  // --------------------------------------------------------- stimulus helpers
  task automatic clear_inputs();
    bus.ram_load_en     = 1'b0;
    bus.ram_store_en    = 1'b0;
    bus.ram_load_addr   = 32'h0;
    bus.ram_store_addr  = 32'h0;
    bus.ram_store_data  = 32'h0;
    bus.ram_store_width = W_B;
    bus.ram_load_width  = W_B;
  endtask

  // Starts and ends just after a rising edge.
  task automatic do_store(input logic [31:0] a, input logic [1:0] w,
                          input logic [31:0] d, input string name);
    sram_exp_t e, o;
    sq.push_back(model_store(a, w, d, 1'b0));
    bus.ram_store_en    = 1'b1;
    bus.ram_store_addr  = a;
    bus.ram_store_width = w;
    bus.ram_store_data  = d;
    @(negedge clk);
    e = sq.pop_front();
    o = observe();
    if (!e.en) begin
      o.addr  = '0;
      o.wdata = '0;
    end
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL %s: got en=%b we=%b addr=%h wdata=%h fault=%b stall=%b, want en=%b we=%b addr=%h wdata=%h fault=%b stall=%b",
               name, o.en, o.we, o.addr, o.wdata, o.fault, o.stall,
               e.en, e.we, e.addr, e.wdata, e.fault, e.stall);
    end
    @(posedge clk); #1;
    bus.ram_store_en = 1'b0;
    shadow_write(e);
  endtask

  // Starts and ends just after a rising edge; holds the request while stalled.
  task automatic do_load(input logic [31:0] a, input logic [1:0] w, input string name);
    logic        ok;
    logic [31:0] exp;
    int          cyc;
    ok = legal(a, w);
    lq.push_back(ok ? model_load(a, w) : 32'h0);
    bus.ram_load_en    = 1'b1;
    bus.ram_load_addr  = a;
    bus.ram_load_width = w;
    @(negedge clk);
    checks++;
    if (bus.sram_en !== ok || bus.sram_we !== 4'b0000 || bus.mem_stall !== ok ||
        bus.access_fault !== !ok || (ok && bus.sram_addr !== a[11:2])) begin
      errors++;
      $display("FAIL %s issue: got en=%b we=%b addr=%h stall=%b fault=%b, want en=%b we=0 addr=%h stall=%b fault=%b",
               name, bus.sram_en, bus.sram_we, bus.sram_addr, bus.mem_stall,
               bus.access_fault, ok, a[11:2], ok, !ok);
    end
    if (ok) begin
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (bus.mem_stall === 1'b1 && cyc < 4);
      checks++;
      if (cyc != 1 || bus.mem_stall !== 1'b0) begin
        errors++;
        $display("FAIL %s latency: got %0d cycles of stall, want 1", name, cyc);
      end
      exp = lq.pop_front();
      checks++;
      if (bus.ram_load_data !== exp) begin
        errors++;
        $display("FAIL %s data: got %h, want %h", name, bus.ram_load_data, exp);
      end
      @(posedge clk); #1;
      bus.ram_load_en = 1'b0;
      @(negedge clk);
    end else begin
      @(posedge clk); #1;
      bus.ram_load_en = 1'b0;
      @(negedge clk);
      exp = lq.pop_front();
    end
    checks++;
    if (bus.ram_load_data !== exp || bus.access_fault !== 1'b0 || bus.mem_stall !== 1'b0) begin
      errors++;
      $display("FAIL %s hold: got data=%h fault=%b stall=%b, want data=%h fault=0 stall=0",
               name, bus.ram_load_data, bus.access_fault, bus.mem_stall, exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if (bus.sram_en !== 1'b0 || bus.sram_we !== 4'b0 || bus.sram_addr !== 10'h0 ||
        bus.sram_wdata !== 32'h0 || bus.mem_stall !== 1'b0 ||
        bus.access_fault !== 1'b0 || bus.ram_load_data !== 32'h0) begin
      errors++;
      $display("FAIL %s: got en=%b we=%b addr=%h wdata=%h stall=%b fault=%b data=%h, want all 0",
               name, bus.sram_en, bus.sram_we, bus.sram_addr, bus.sram_wdata,
               bus.mem_stall, bus.access_fault, bus.ram_load_data);
    end
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    // Requests present during reset must not leak onto any output.
    bus.ram_load_en     = 1'b1;
    bus.ram_load_addr   = BASE;
    bus.ram_load_width  = W_W;
    bus.ram_store_en    = 1'b1;
    bus.ram_store_addr  = BASE + 32'h4;
    bus.ram_store_width = W_W;
    bus.ram_store_data  = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    check_all_zero("reset_outputs");
    @(posedge clk); #1;
    clear_inputs();
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("post_reset_idle");
    @(posedge clk); #1;
  endtask

  task automatic test_store();
    do_store(BASE + 32'h3, W_B, 32'h0000_00A5, "store_byte_off3");
    do_store(BASE + 32'h6, W_H, 32'h1234_BEEF, "store_half_off2");
    do_store(BASE + 32'h9, W_B, 32'hFFFF_FF3C, "store_byte_off1");
    do_store(BASE + 32'h0, W_W, 32'h8765_4321, "store_word");
  endtask

  task automatic test_load();
    do_load(BASE + 32'h2, W_H, "load_half_off2");
    do_load(BASE + 32'h1, W_B, "load_byte_off1");
    do_load(BASE + 32'h3, W_B, "load_byte_off3");
    do_load(BASE + 32'h0, W_W, "load_word");
    do_load(BASE + 32'h4, W_H, "load_half_word1");
    do_load(BASE + 32'h8, W_W, "load_word2_partial");
  endtask

  task automatic test_fault();
    do_load(BASE + 32'h2, W_W, "fault_load_word_misaligned");
    do_load(BASE + 32'h1, W_H, "fault_load_half_odd");
    do_load(BASE - 32'h4, W_W, "fault_load_below_window");
    do_store(BASE + 32'h1000, W_W, 32'h5555_AAAA, "fault_store_outside");
    do_store(BASE + 32'h20, 2'b11, 32'h1111_2222, "fault_store_width11");
    do_store(BASE + 32'h3, W_H, 32'h0000_7777, "fault_store_half_odd");
    // Word 0 must be untouched by the out-of-window store that aliases it.
    do_load(BASE + 32'h0, W_W, "fault_no_write_word0");
  endtask

  task automatic test_load_store_same_cycle();
    sram_exp_t e, o;
    logic [31:0] exp;
    sq.push_back(model_store(BASE + 32'h4, W_W, 32'hCAFE_F00D, 1'b1));
    bus.ram_store_en    = 1'b1;
    bus.ram_store_addr  = BASE + 32'h4;
    bus.ram_store_width = W_W;
    bus.ram_store_data  = 32'hCAFE_F00D;
    bus.ram_load_en     = 1'b1;
    bus.ram_load_addr   = BASE + 32'h4;
    bus.ram_load_width  = W_W;
    @(negedge clk);
    e = sq.pop_front();
    o = observe();
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL both_store_first: got en=%b we=%b addr=%h wdata=%h fault=%b stall=%b, want en=%b we=%b addr=%h wdata=%h fault=%b stall=%b",
               o.en, o.we, o.addr, o.wdata, o.fault, o.stall,
               e.en, e.we, e.addr, e.wdata, e.fault, e.stall);
    end
    shadow_write(e);
    lq.push_back(model_load(BASE + 32'h4, W_W));
    @(negedge clk);
    checks++;
    if (bus.sram_en !== 1'b1 || bus.sram_we !== 4'b0000 || bus.sram_addr !== 10'h1 ||
        bus.mem_stall !== 1'b1 || bus.access_fault !== 1'b0) begin
      errors++;
      $display("FAIL both_load_issue: got en=%b we=%b addr=%h stall=%b fault=%b, want en=1 we=0 addr=001 stall=1 fault=0",
               bus.sram_en, bus.sram_we, bus.sram_addr, bus.mem_stall, bus.access_fault);
    end
    @(negedge clk);
    exp = lq.pop_front();
    checks++;
    if (bus.mem_stall !== 1'b0 || bus.ram_load_data !== exp || bus.sram_en !== 1'b0) begin
      errors++;
      $display("FAIL both_load_data: got stall=%b en=%b data=%h, want stall=0 en=0 data=%h",
               bus.mem_stall, bus.sram_en, bus.ram_load_data, exp);
    end
    @(posedge clk); #1;
    clear_inputs();
    @(negedge clk);
    checks++;
    if (bus.ram_load_data !== exp || bus.sram_en !== 1'b0) begin
      errors++;
      $display("FAIL both_hold: got data=%h en=%b, want data=%h en=0",
               bus.ram_load_data, bus.sram_en, exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_in_load_wait();
    bus.ram_load_en    = 1'b1;
    bus.ram_load_addr  = BASE + 32'h4;
    bus.ram_load_width = W_W;
    @(negedge clk);
    checks++;
    if (bus.mem_stall !== 1'b1) begin
      errors++;
      $display("FAIL rst_wait_issue: got stall=%b, want 1", bus.mem_stall);
    end
    @(posedge clk); #1;   // now in LOAD_WAIT, request still held
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_in_load_wait");
    @(posedge clk); #1;
    clear_inputs();
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("rst_aborted_load");
    @(posedge clk); #1;
    do_load(BASE + 32'h4, W_W, "load_after_reset");
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    logic [1:0]  w;
    for (int i = 0; i < 6; i++) begin
      w = (i % 3 == 0) ? W_B : ((i % 3 == 1) ? W_H : W_W);
      a = BASE + 32'h40 + 32'(4 * i);
      if (w == W_B) a = a + 32'(i % 4);
      if (w == W_H) a = a + 32'((i % 2) * 2);
      do_store(a, w, $urandom, "b2b_store");
    end
    for (int i = 0; i < 6; i++)
      do_load(BASE + 32'h40 + 32'(4 * i), W_W, "b2b_load_word");
    do_load(BASE + 32'h46, W_H, "b2b_load_half");
    do_load(BASE + 32'h4B, W_B, "b2b_load_byte");
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_store();
    test_load();
    test_fault();
    test_load_store_same_cycle();
    test_reset_in_load_wait();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter ADDR_W, default 10, SHALL set the SRAM word-address width (4 KiB at the default).
REQ-002 Parameter BASE_ADDR, default 32'h0000_1000, SHALL set the byte base address of the window; the window SHALL be 4 KiB aligned.
REQ-003 Ports (name  dir  width  meaning):
- clk  in  1  single clock; all logic on its rising edge
- rst_n  in  1  asynchronous active-low reset
- ram_load_en  in  1  load request from the execute stage
- ram_store_en  in  1  store request from the execute stage
- ram_load_addr  in  32  load byte address
- ram_store_addr  in  32  store byte address
- ram_store_data  in  32  store data, right-justified
- ram_store_width  in  2  00 byte, 01 halfword, 10 word
- ram_load_width  in  2  same encoding, for the load
- ram_load_data  out  32  load data, right-justified; sign/zero extension is done by the core
- mem_stall  out  1  core SHALL hold its request while this is high
- access_fault  out  1  one-cycle pulse on a misaligned or out-of-window access
- sram_en  out  1  SRAM access strobe
- sram_we  out  4  byte write enables
- sram_addr  out  ADDR_W  SRAM word address
- sram_wdata  out  32  lane-aligned write data
- sram_rdata  in  32  SRAM read data, valid the cycle after sram_en with sram_we==0

Function
REQ-004 The FSM SHALL have states IDLE and LOAD_WAIT.
REQ-005 Window hit: addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2].
REQ-006 Misaligned: halfword with addr[0]=1, word with addr[1:0]!=0, or width 11.
REQ-007 Store (IDLE, hit, aligned): combinationally assert sram_en, sram_addr=addr[ADDR_W+1:2].
- sram_we: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
- sram_wdata replicates the data: byte {4{d[7:0]}}, half {2{d[15:0]}}, word d.
- mem_stall stays 0; the store completes in 1 cycle.
REQ-008 Load (IDLE, hit, aligned):
- Combinationally assert sram_en, sram_we=0, and mem_stall=1.
- Register addr[1:0] and width, then enter LOAD_WAIT.
REQ-009 In LOAD_WAIT:
- Drive ram_load_data = sram_rdata >> (8*offset), masked to width (byte 8 bits, half 16 bits, word 32 bits).
- Latch that value into a hold register.
- mem_stall=0; return to IDLE.
- Load-to-use latency is therefore exactly 2 cycles.
REQ-010 Outside LOAD_WAIT, ram_load_data SHALL present the hold register, so it stays stable until the next load completes.
REQ-011 When ram_load_en and ram_store_en are both high in IDLE:
- The store SHALL be served first with mem_stall=1.
- The load SHALL be issued the following cycle.
REQ-012 A request that misses the window or is misaligned SHALL:
- not touch the SRAM (sram_en=0);
- pulse access_fault for 1 cycle;
- keep mem_stall=0;
- for a load, set the hold register to 0.
REQ-013 Requests arriving in LOAD_WAIT SHALL be ignored; the core is stalled then, so it re-presents them in IDLE.
REQ-014 sram_en, sram_we and access_fault SHALL be 0 whenever no qualifying request is present.

Reset
REQ-015 While rst_n=0, all outputs SHALL be 0:
- FSM=IDLE, hold register=0, mem_stall=0, access_fault=0, sram_en=0, sram_we=0.
REQ-016 Reset asserted in LOAD_WAIT SHALL abort the load; no data is returned and the FSM restarts in IDLE.

Structure
REQ-017 The FSM state enum, the width encoding constants (MEM_BYTE/MEM_HALF/MEM_WORD) and the lane-mask function SHALL live in CoreConfig, shared with the execute stage.
REQ-018 Lane extraction and byte-enable generation SHALL be one combinational sub-module, mem_lane_align, reused on the read and write paths.

Verification
REQ-019 Store byte 0xA5 at BASE+3 -> same cycle sram_we=4'b1000, sram_addr=0, sram_wdata=32'hA5A5A5A5; mem_stall=0.
REQ-020 SRAM word0=32'h8765_4321, load half at BASE+2 -> mem_stall=1 in cycle N; ram_load_data=32'h0000_8765 in N+1 and held afterwards.
REQ-021 Load word at BASE+2 -> access_fault pulses 1 cycle, sram_en=0, ram_load_data=0.
REQ-022 Load and store both asserted in IDLE -> store written in cycle N with stall; load issued in N+1; data returned in N+2.
REQ-023 Store at BASE+32'h1000 (outside the window) -> access_fault=1, no SRAM write.
REQ-024 rst_n driven low during LOAD_WAIT -> all outputs 0 immediately; after release, the next load completes normally.
